// File: rtl/data_mem_arbiter_pkg.sv
// Shared widths, limits and enums for the data-memory arbiter and its dump engine.
package data_mem_arbiter_pkg;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned LEN_W      = 4;
  localparam int unsigned ISS_W      = LEN_W + 1;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned STARVE_MAX = 4;

  typedef enum logic {
    IDLE,
    DUMP
  } state_e;

  typedef enum logic [1:0] {
    OwnNone,
    OwnCpu,
    OwnDump
  } owner_e;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// CPU, dump and memory bus bundle; slave is the arbiter's view, master the environment's.
interface data_mem_arbiter_if;
  import data_mem_arbiter_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              dbg_start;
  logic [ADDR_W-1:0] dbg_base;
  logic [LEN_W-1:0]  dbg_len;
  logic              dbg_busy;
  logic              dbg_valid;
  logic [LEN_W-1:0]  dbg_idx;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_done;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dbg_start, dbg_base, dbg_len,
    output dbg_busy, dbg_valid, dbg_idx, dbg_data, dbg_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dbg_start, dbg_base, dbg_len,
    input  dbg_busy, dbg_valid, dbg_idx, dbg_data, dbg_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/starve_counter.sv
// Saturating count of cycles the dump engine has been denied the memory port.
module starve_counter
  import data_mem_arbiter_pkg::*;
(
  input  logic CLK,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign sat = (cnt_q == CNT_W'(STARVE_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port RAM between the CPU memory stage and a background dump engine;
// the CPU wins every cycle unless the dump has been starved for STARVE_MAX cycles.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
(
  input  logic               CLK,
  input  logic               rst,
  data_mem_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ISS_W-1:0]  iss_q, iss_d;
  logic [LEN_W-1:0]  ret_q, ret_d;

  logic dump_pending;
  logic starve_sat;
  logic grant_cpu;
  logic grant_dump;

  // Gating with rst keeps the dump side silent throughout a reset cycle.
  assign dump_pending = rst && (state_q == DUMP) && (iss_q <= {1'b0, len_q});
  assign grant_cpu    = bus.cpu_req && !(dump_pending && starve_sat);
  assign grant_dump   = dump_pending && !grant_cpu;

  starve_counter u_starve_counter (
    .CLK (CLK),
    .rst (rst),
    .inc (dump_pending && !grant_dump),
    .clr (grant_dump || (state_q == IDLE)),
    .sat (starve_sat)
  );

  assign bus.cpu_stall = bus.cpu_req && !grant_cpu;
  assign bus.mem_en    = grant_cpu || grant_dump;
  assign bus.mem_we    = grant_cpu && bus.cpu_we;
  assign bus.mem_addr  = grant_cpu ? bus.cpu_addr : (grant_dump ? addr_q : '0);
  assign bus.mem_wdata = grant_cpu ? bus.cpu_wdata : '0;

  assign bus.cpu_rvalid = rst && (owner_q == OwnCpu);
  assign bus.dbg_valid  = rst && (owner_q == OwnDump);
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
  assign bus.dbg_data   = bus.dbg_valid ? bus.mem_rdata : '0;
  assign bus.dbg_idx    = rst ? ret_q : '0;
  assign bus.dbg_done   = bus.dbg_valid && (ret_q == len_q);
  assign bus.dbg_busy   = rst && (state_q == DUMP);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    iss_d   = iss_q;
    ret_d   = ret_q;
    owner_d = OwnNone;

    // Writes return nothing, so only reads claim the next-cycle data slot.
    if (grant_cpu && !bus.cpu_we) begin
      owner_d = OwnCpu;
    end else if (grant_dump) begin
      owner_d = OwnDump;
    end

    if (grant_dump) begin
      addr_d = addr_q + ADDR_W'(1);
      iss_d  = iss_q + ISS_W'(1);
    end
    if (bus.dbg_valid) begin
      ret_d = ret_q + LEN_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (bus.dbg_start) begin
          state_d = DUMP;
          addr_d  = bus.dbg_base;
          len_d   = bus.dbg_len;
          iss_d   = '0;
          ret_d   = '0;
        end
      end
      DUMP: begin
        if (bus.dbg_done) begin
          state_d = IDLE;
          iss_d   = '0;
          ret_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OwnNone;
      addr_q  <= '0;
      len_q   <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Random and directed stimulus for data_mem_arbiter, checked every cycle against a
// transaction-level model (shadow memory, issue/return counts, starvation tally).
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  logic CLK = 1'b0;
  logic rst;

  data_mem_arbiter_if bus ();

  data_mem_arbiter dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Single-port synchronous RAM, 1-cycle read latency.
  logic [15:0] ram [256];
  always @(posedge CLK) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  // Reference model state.
  int shadow [256];
  int m_busy, m_words, m_issued, m_base, m_starve;
  int m_own;  // 0 none, 1 cpu read, 2 dump read in flight
  int m_data, m_idx;

  int n_checks, n_pass;
  int done_cnt, stall_cnt, rv_cnt;
  int dlog[$];
  int alog[$];
  bit was_stalled;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic cycle();
    bit pend, gc, gd, cv, dv, last, r, req, we, start;
    int addr, a, wd, base, len;
    @(negedge CLK);
    r     = rst;
    req   = bus.cpu_req;
    we    = bus.cpu_we;
    a     = int'(bus.cpu_addr);
    wd    = int'(bus.cpu_wdata);
    start = bus.dbg_start;
    base  = int'(bus.dbg_base);
    len   = int'(bus.dbg_len);

    pend = r && m_busy != 0 && m_issued < m_words;
    gc   = req && !(pend && m_starve >= STARVE_MAX);
    gd   = pend && !gc;
    addr = (m_base + m_issued) % 256;
    cv   = r && m_own == 1;
    dv   = r && m_own == 2;
    last = dv && m_idx == m_words - 1;

    check("cpu_stall", bus.cpu_stall, req && !gc);
    check("mem_en", bus.mem_en, gc || gd);
    check("mem_we", bus.mem_we, gc && we);
    check("mem_addr", bus.mem_addr, gc ? a : (gd ? addr : 0));
    check("mem_wdata", bus.mem_wdata, gc ? wd : 0);
    check("cpu_rvalid", bus.cpu_rvalid, cv);
    check("cpu_rdata", bus.cpu_rdata, cv ? m_data : 0);
    check("dbg_valid", bus.dbg_valid, dv);
    check("dbg_data", bus.dbg_data, dv ? m_data : 0);
    if (dv || !r) check("dbg_idx", bus.dbg_idx, dv ? m_idx : 0);
    check("dbg_done", bus.dbg_done, last);
    check("dbg_busy", bus.dbg_busy, r && m_busy != 0);

    if (bus.dbg_valid) dlog.push_back(int'(bus.dbg_data));
    if (gd) alog.push_back(int'(bus.mem_addr));
    if (bus.dbg_done) done_cnt++;
    if (bus.cpu_stall) stall_cnt++;
    if (bus.cpu_rvalid) rv_cnt++;
    was_stalled = bus.cpu_stall;

    @(posedge CLK);
    if (gc && !we) begin
      m_own = 1; m_data = shadow[a];
    end else if (gd) begin
      m_own = 2; m_data = shadow[addr]; m_idx = m_issued;
    end else begin
      m_own = 0;
    end
    if (gc && we) shadow[a] = wd & 16'hFFFF;
    if (!r) begin
      m_busy = 0; m_starve = 0; m_own = 0; m_issued = 0;
    end else begin
      if (m_busy == 0 || gd) m_starve = 0;
      else if (pend && m_starve < STARVE_MAX) m_starve++;
      if (gd) m_issued++;
      if (last) m_busy = 0;
      else if (m_busy == 0 && start) begin
        m_busy = 1; m_base = base; m_words = len + 1; m_issued = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_start = 0; bus.dbg_base = '0; bus.dbg_len = '0;
  endtask

  task automatic start_dump(input int base, input int len);
    bus.dbg_start = 1; bus.dbg_base = base[7:0]; bus.dbg_len = len[3:0];
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (m_busy != 0 && k < budget) begin
      cycle();
      k++;
    end
    if (m_busy != 0) check("dump_timeout", 1, 0);
  endtask

  task automatic clear_logs();
    dlog.delete(); alog.delete();
    done_cnt = 0; stall_cnt = 0; rv_cnt = 0;
  endtask

  initial begin
    int exp033 [4];
    n_checks = 0; n_pass = 0;
    m_busy = 0; m_words = 1; m_issued = 0; m_base = 0; m_starve = 0; m_own = 0;
    m_data = 0; m_idx = 0;
    for (int i = 0; i < 256; i++) begin
      shadow[i] = int'($urandom_range(16'hFFFF));
      if (i == 50) shadow[i] = 1;
      if (i == 51) shadow[i] = 100;
      ram[i] <= shadow[i][15:0];
    end
    idle_inputs();
    rst = 0;
    repeat (3) cycle();
    rst = 1;
    repeat (2) cycle();

    // Two-word dump with the CPU idle.
    clear_logs();
    start_dump(50, 1);
    cycle();
    bus.dbg_start = 0;
    wait_idle(20);
    check("t031_words", dlog.size(), 2);
    check("t031_idx0", dlog[0], 1);
    check("t031_idx1", dlog[1], 100);
    check("t031_done", done_cnt, 1);

    // Continuous CPU reads against a 16-word dump.
    clear_logs();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'd5;
    start_dump(0, 15);
    cycle();
    bus.dbg_start = 0;
    wait_idle(200);
    check("t032_words", dlog.size(), 16);
    check("t032_stalls", stall_cnt, 16);
    idle_inputs();
    repeat (2) cycle();

    // Address wrap.
    clear_logs();
    start_dump(8'hFE, 3);
    cycle();
    bus.dbg_start = 0;
    wait_idle(20);
    exp033 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    check("t033_cnt", alog.size(), 4);
    for (int i = 0; i < 4; i++) check("t033_addr", alog[i], exp033[i]);

    // CPU write lands just before the dump reads that word.
    clear_logs();
    start_dump(8, 7);
    cycle();
    bus.dbg_start = 0;
    repeat (2) cycle();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 8'd10; bus.cpu_wdata = 16'd624;
    cycle();
    idle_inputs();
    wait_idle(30);
    check("t034_addr2", alog[2], 10);
    check("t034_data2", dlog[2], 624);
    check("t034_no_rvalid", rv_cnt, 0);

    // Restart while busy is ignored; reset mid-dump abandons it.
    clear_logs();
    start_dump(100, 5);
    cycle();
    start_dump(0, 15);
    repeat (2) cycle();
    bus.dbg_start = 0;
    wait_idle(30);
    check("t035_done", done_cnt, 1);
    check("t035_words", dlog.size(), 6);
    start_dump(30, 9);
    cycle();
    bus.dbg_start = 0;
    repeat (4) cycle();
    clear_logs();
    rst = 0;
    cycle();
    rst = 1;
    repeat (15) cycle();
    check("t035_rst_done", done_cnt, 0);
    check("t035_rst_valid", dlog.size(), 0);

    // Simultaneous CPU read and dump start.
    clear_logs();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'd77;
    start_dump(40, 2);
    cycle();
    check("t036_no_early_dump", alog.size(), 0);
    idle_inputs();
    cycle();
    check("t036_rvalid", rv_cnt, 1);
    wait_idle(20);
    check("t036_words", dlog.size(), 3);

    // Random traffic; a stalled CPU holds its request.
    for (int c = 0; c < 1500; c++) begin
      if (!was_stalled) begin
        bus.cpu_req   = ($urandom_range(2) != 0);
        bus.cpu_we    = $urandom_range(1) == 1;
        bus.cpu_addr  = 8'($urandom_range(255));
        bus.cpu_wdata = 16'($urandom_range(16'hFFFF));
      end
      bus.dbg_start = ($urandom_range(7) == 0);
      bus.dbg_base  = 8'($urandom_range(255));
      bus.dbg_len   = 4'($urandom_range(15));
      rst = ($urandom_range(199) != 0);
      cycle();
    end
    rst = 1;
    idle_inputs();
    wait_idle(40);
    repeat (2) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
